// File: rtl/pwm_duty_meter.sv
// PWM decoder: measures high time and period of an asynchronous PWM input in CLK cycles
// and recovers the duty code with a restoring shift-subtract divider.
module pwm_duty_meter #(
    parameter int CNT_W       = 24,
    parameter int DUTY_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              en,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  high_time,
    output logic [CNT_W-1:0]  period,
    output logic              valid,
    output logic              stuck
);
    localparam int DC_W = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;
    localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DUTY_W - 1);
    localparam logic [DC_W-1:0]  DC_ONE  = DC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    // Timeout fires on the cycle the period counter would reach all-ones.
    localparam logic [CNT_W-1:0] TO_CNT  = {{(CNT_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DIV  = 2'd3
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_s, pwm_d, rise, fall, timeout;
    logic [CNT_W-1:0]       hi_cnt, hi_n, per_cnt, per_n;
    logic [CNT_W-1:0]       num, num_n, den, den_n, rem, rem_n, rem_sub;
    logic [CNT_W:0]         rem_sh;
    logic                   rem_ge;
    logic [DUTY_W-1:0]      q, q_n, q_sh;
    logic [DC_W-1:0]        div_cnt, dc_n;
    logic [DUTY_W-1:0]      duty_n;
    logic [CNT_W-1:0]       high_time_n, period_n;
    logic                   valid_n, stuck_n;

    assign pwm_s   = sync_q[SYNC_STAGES-1];
    assign rise    = pwm_s & ~pwm_d;
    assign fall    = ~pwm_s & pwm_d;
    assign timeout = (state != S_DIV) && (per_cnt == TO_CNT);

    // The remainder is always below the divisor, so the subtraction fits in CNT_W bits.
    assign rem_sh  = {rem, 1'b0};
    assign rem_ge  = (rem_sh >= {1'b0, den});
    assign rem_sub = rem_sh[CNT_W-1:0] - den;
    assign q_sh    = {q[DUTY_W-2:0], rem_ge};

    // Input synchroniser and one-cycle delayed copy for edge detection.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            pwm_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            pwm_d  <= pwm_s;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= S_WAIT;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, counter, divider and output update logic.
    always_comb begin
        state_n     = state;
        hi_n        = hi_cnt;
        per_n       = per_cnt;
        num_n       = num;
        den_n       = den;
        rem_n       = rem;
        q_n         = q;
        dc_n        = div_cnt;
        duty_n      = duty;
        high_time_n = high_time;
        period_n    = period;
        valid_n     = 1'b0;
        stuck_n     = stuck;
        if (!en) begin
            state_n = S_WAIT;
            hi_n    = {CNT_W{1'b0}};
            per_n   = {CNT_W{1'b0}};
            num_n   = {CNT_W{1'b0}};
            den_n   = {CNT_W{1'b0}};
            rem_n   = {CNT_W{1'b0}};
            q_n     = {DUTY_W{1'b0}};
            dc_n    = {DC_W{1'b0}};
        end else if (timeout) begin
            duty_n      = pwm_s ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};
            high_time_n = {CNT_W{1'b0}};
            period_n    = {CNT_W{1'b0}};
            stuck_n     = 1'b1;
            valid_n     = 1'b1;
            state_n     = S_WAIT;
            hi_n        = {CNT_W{1'b0}};
            per_n       = {CNT_W{1'b0}};
        end else begin
            case (state)
                S_WAIT: begin
                    if (rise) begin
                        hi_n    = CNT_ONE;
                        per_n   = CNT_ONE;
                        state_n = S_HIGH;
                    end else begin
                        per_n = per_cnt + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        per_n   = per_cnt + CNT_ONE;
                        state_n = S_LOW;
                    end else begin
                        hi_n  = hi_cnt + CNT_ONE;
                        per_n = per_cnt + CNT_ONE;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        num_n   = hi_cnt;
                        den_n   = per_cnt;
                        rem_n   = hi_cnt;
                        q_n     = {DUTY_W{1'b0}};
                        dc_n    = {DC_W{1'b0}};
                        hi_n    = {CNT_W{1'b0}};
                        per_n   = {CNT_W{1'b0}};
                        state_n = S_DIV;
                    end else begin
                        per_n = per_cnt + CNT_ONE;
                    end
                end
                S_DIV: begin
                    rem_n = rem_ge ? rem_sub : rem_sh[CNT_W-1:0];
                    q_n   = q_sh;
                    if (div_cnt == DC_LAST) begin
                        duty_n      = q_sh;
                        high_time_n = num;
                        period_n    = den;
                        stuck_n     = 1'b0;
                        valid_n     = 1'b1;
                        dc_n        = {DC_W{1'b0}};
                        state_n     = S_WAIT;
                    end else begin
                        dc_n = div_cnt + DC_ONE;
                    end
                end
                default: begin
                    state_n = S_WAIT;
                end
            endcase
        end
    end

    // Datapath and registered output update.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            hi_cnt    <= {CNT_W{1'b0}};
            per_cnt   <= {CNT_W{1'b0}};
            num       <= {CNT_W{1'b0}};
            den       <= {CNT_W{1'b0}};
            rem       <= {CNT_W{1'b0}};
            q         <= {DUTY_W{1'b0}};
            div_cnt   <= {DC_W{1'b0}};
            duty      <= {DUTY_W{1'b0}};
            high_time <= {CNT_W{1'b0}};
            period    <= {CNT_W{1'b0}};
            valid     <= 1'b0;
            stuck     <= 1'b0;
        end else begin
            hi_cnt    <= hi_n;
            per_cnt   <= per_n;
            num       <= num_n;
            den       <= den_n;
            rem       <= rem_n;
            q         <= q_n;
            div_cnt   <= dc_n;
            duty      <= duty_n;
            high_time <= high_time_n;
            period    <= period_n;
            valid     <= valid_n;
            stuck     <= stuck_n;
        end
    end
endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter: waveforms described as (high, low) periods,
// expected results derived from duty = floor(high*2^DUTY_W/period) and event timing rules.
module tb_pwm_duty_meter;
    localparam int CW  = 8;
    localparam int DW  = 5;
    localparam int SS  = 2;
    localparam int LAT = SS + DW + 1;
    localparam int TO  = (1 << CW) - 1;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [DW-1:0] duty;
        logic [CW-1:0] ht;
        logic [CW-1:0] per;
        logic          stuck;
    } ev_t;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          en = 1'b1;
    logic          pwm_in = 1'b0;
    logic [DW-1:0] duty;
    logic [CW-1:0] high_time, period;
    logic          valid, stuck;

    ev_t got[$];
    ev_t exp_q[$];
    int  ph[$], pl[$], prc[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  stable_err = 0;
    int  t0 = 0;
    logic [DW+2*CW:0] prev_out = '0;

    pwm_duty_meter #(.CNT_W(CW), .DUTY_W(DW), .SYNC_STAGES(SS)) dut (
        .CLK(CLK), .Reset(Reset), .en(en), .pwm_in(pwm_in),
        .duty(duty), .high_time(high_time), .period(period),
        .valid(valid), .stuck(stuck)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Logs every valid pulse and flags output changes that happen without one.
    always @(negedge CLK) begin
        if (Reset) begin
            prev_out = {duty, high_time, period, stuck};
        end else if (valid) begin
            got.push_back({32'(cyc), duty, high_time, period, stuck});
            prev_out = {duty, high_time, period, stuck};
        end else if ({duty, high_time, period, stuck} !== prev_out) begin
            stable_err++;
            prev_out = {duty, high_time, period, stuck};
        end
    end

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            pwm_in = v;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1; pwm_in = 1'b0; en = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK); #1;
        Reset = 1'b0;
        t0 = cyc;
    endtask

    task automatic new_run();
        ph.delete(); pl.delete(); prc.delete(); got.delete(); exp_q.delete();
    endtask

    task automatic add_period(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            ph.push_back(h); pl.push_back(l);
        end
    endtask

    task automatic drive_periods();
        for (int i = 0; i < ph.size(); i++) begin
            @(posedge CLK); #1;
            pwm_in = 1'b1;
            prc.push_back(cyc);
            hold(1'b1, ph[i] - 1);
            hold(1'b0, pl[i]);
        end
        hold(1'b0, 12);
    endtask

    // Reference: every other period is measured, reported LAT cycles after its closing rise.
    task automatic build_exp();
        ev_t e;
        for (int i = 0; i + 1 < ph.size(); i += 2) begin
            e.cyc   = 32'(prc[i+1] + LAT);
            e.duty  = DW'((ph[i] << DW) / (ph[i] + pl[i]));
            e.ht    = CW'(ph[i]);
            e.per   = CW'(ph[i] + pl[i]);
            e.stuck = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            pwm_in = 1'($urandom_range(1, 0));
        end
        @(negedge CLK);
        total++;
        if ({duty, high_time, period, valid, stuck} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got duty=%0d ht=%0d per=%0d valid=%0b stuck=%0b exp all 0",
                     duty, high_time, period, valid, stuck);
        end
        do_reset();
        new_run();
        hold(1'b0, 20);
        total++;
        if (got.size() !== 0) begin
            bad++;
            $display("FAIL reset_no_valid got=%0d pulses exp=0", got.size());
        end
    endtask

    task automatic test_fixed();
        int tab[4][3] = '{'{10, 22, 10}, '{20, 44, 10}, '{31, 1, 31}, '{1, 31, 1}};
        for (int t = 0; t < 4; t++) begin
            do_reset();
            new_run();
            add_period(tab[t][0], tab[t][1], 4);
            drive_periods();
            build_exp();
            total++;
            if (got.size() !== exp_q.size()) begin
                bad++;
                $display("FAIL fixed%0d_count got=%0d exp=%0d", t, got.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < got.size()) begin
                total++;
                if (got[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL fixed%0d_ev%0d got=%h exp=%h", t, i, got[i], exp_q[i]);
                end
            end
            if (got.size() > 0) begin
                total++;
                if (got[0].duty !== DW'(tab[t][2])) begin
                    bad++;
                    $display("FAIL fixed%0d_duty got=%0d exp=%0d", t, got[0].duty, tab[t][2]);
                end
            end
        end
    endtask

    task automatic test_random();
        int h, l;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            new_run();
            for (int i = 0; i < 8; i++) begin
                h = $urandom_range(40, 1);
                l = $urandom_range(40, 1);
                if (h + l < 8) l = 8 - h;
                add_period(h, l, 1);
            end
            drive_periods();
            build_exp();
            total++;
            if (got.size() !== exp_q.size()) begin
                bad++;
                $display("FAIL random%0d_count got=%0d exp=%0d", r, got.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < got.size()) begin
                total++;
                if (got[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL random%0d_ev%0d got=%h exp=%h", r, i, got[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        for (int lvl = 0; lvl < 2; lvl++) begin
            do_reset();
            new_run();
            pwm_in = 1'(lvl);
            for (int j = 0; j < 2; j++)
                exp_q.push_back({32'(t0 + lvl * SS + TO * (j + 1)),
                                 (lvl == 1) ? {DW{1'b1}} : {DW{1'b0}}, {CW{1'b0}}, {CW{1'b0}}, 1'b1});
            hold(1'(lvl), 600);
            total++;
            if (got.size() !== exp_q.size()) begin
                bad++;
                $display("FAIL timeout%0d_count got=%0d exp=%0d", lvl, got.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < got.size()) begin
                total++;
                if (got[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL timeout%0d_ev%0d got=%h exp=%h", lvl, i, got[i], exp_q[i]);
                end
            end
        end
        hold(1'b0, 5);
        new_run();
        add_period(10, 22, 4);
        drive_periods();
        build_exp();
        total++;
        if (got.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL stuck_clear_count got=%0d exp=%0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL stuck_clear_ev%0d got=%h exp=%h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_high();
        do_reset();
        new_run();
        add_period(10, 22, 2);
        drive_periods();
        build_exp();
        total++;
        if (got.size() !== 1 || got[0] !== exp_q[0]) begin
            bad++;
            $display("FAIL midrst_pre got=%0d pulses exp=1 (%h)", got.size(), exp_q[0]);
        end
        @(posedge CLK); #1;
        pwm_in = 1'b1;
        hold(1'b1, 5);
        Reset = 1'b1;
        #1;
        total++;
        if ({duty, high_time, period, valid, stuck} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs got duty=%0d ht=%0d per=%0d valid=%0b stuck=%0b exp all 0",
                     duty, high_time, period, valid, stuck);
        end
        pwm_in = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK); #1;
        Reset = 1'b0;
        new_run();
        add_period(10, 22, 4);
        drive_periods();
        build_exp();
        total++;
        if (got.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL midrst_count got=%0d exp=%0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL midrst_ev%0d got=%h exp=%h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_en_drop();
        ev_t held;
        do_reset();
        new_run();
        add_period(12, 20, 2);
        drive_periods();
        build_exp();
        held = exp_q[0];
        @(posedge CLK); #1;
        pwm_in = 1'b1;
        hold(1'b1, 11);
        hold(1'b0, 5);
        en = 1'b0;
        hold(1'b0, 20);
        total++;
        if (got.size() !== 1) begin
            bad++;
            $display("FAIL endrop_count got=%0d exp=1", got.size());
        end
        total++;
        if ({duty, high_time, period, stuck} !== {held.duty, held.ht, held.per, held.stuck}) begin
            bad++;
            $display("FAIL endrop_hold got duty=%0d ht=%0d per=%0d exp duty=%0d ht=%0d per=%0d",
                     duty, high_time, period, held.duty, held.ht, held.per);
        end
        en = 1'b1;
        new_run();
        add_period(8, 24, 4);
        drive_periods();
        build_exp();
        total++;
        if (got.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL enrestart_count got=%0d exp=%0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL enrestart_ev%0d got=%h exp=%h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_output_stability();
        total++;
        if (stable_err !== 0) begin
            bad++;
            $display("FAIL output_stability got=%0d changes without valid exp=0", stable_err);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_random();
        test_timeout();
        test_reset_mid_high();
        test_en_drop();
        test_output_stability();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
